// File: rtl/demux2_stream_24.sv
// Registered 1-to-2 stream demultiplexer with an independent FIFO per output port.
// Optional per-port accept counters are compiled in with DEMUX24_CNT_EN.
module demux2_stream_24 #(
    parameter int unsigned k     = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [k-1:0] in_data,
    input  logic         sel_i,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [k-1:0] a_data,
    output logic         b_valid,
    input  logic         b_ready,
    output logic [k-1:0] b_data
`ifdef DEMUX24_CNT_EN
    ,
    output logic [15:0]  cnt_a,
    output logic [15:0]  cnt_b
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [k-1:0]  mem_a [DEPTH];
    logic [k-1:0]  mem_b [DEPTH];
    logic [PW-1:0] wr_a, rd_a, wr_b, rd_b;
    logic [CW-1:0] count_a, count_b;

    logic full_a, full_b;
    logic push_a, push_b, pop_a, pop_b;

    // Handshake decode: readiness depends only on the selected port's occupancy.
    always_comb begin
        full_a   = (count_a == CW'(DEPTH));
        full_b   = (count_b == CW'(DEPTH));
        in_ready = sel_i ? !full_b : !full_a;
        push_a   = in_valid && !sel_i && !full_a;
        push_b   = in_valid &&  sel_i && !full_b;
        pop_a    = a_valid && a_ready;
        pop_b    = b_valid && b_ready;
    end

    assign a_valid = (count_a != '0);
    assign b_valid = (count_b != '0);
    assign a_data  = mem_a[rd_a];
    assign b_data  = mem_b[rd_b];

    // Storage arrays carry no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (push_a && !rst) mem_a[wr_a] <= in_data;
        if (push_b && !rst) mem_b[wr_b] <= in_data;
    end

    // Port A pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a    <= '0;
            rd_a    <= '0;
            count_a <= '0;
        end else begin
            if (push_a) wr_a <= wr_a + PW'(1);
            if (pop_a)  rd_a <= rd_a + PW'(1);
            case ({push_a, pop_a})
                2'b10:   count_a <= count_a + CW'(1);
                2'b01:   count_a <= count_a - CW'(1);
                default: count_a <= count_a;
            endcase
        end
    end

    // Port B pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_b    <= '0;
            rd_b    <= '0;
            count_b <= '0;
        end else begin
            if (push_b) wr_b <= wr_b + PW'(1);
            if (pop_b)  rd_b <= rd_b + PW'(1);
            case ({push_b, pop_b})
                2'b10:   count_b <= count_b + CW'(1);
                2'b01:   count_b <= count_b - CW'(1);
                default: count_b <= count_b;
            endcase
        end
    end

`ifdef DEMUX24_CNT_EN
    // Accepted-word counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (push_a) cnt_a <= cnt_a + 16'd1;
            if (push_b) cnt_b <= cnt_b + 16'd1;
        end
    end
`endif

endmodule
